// File: rtl/lut_neuron_sweeper_pkg.sv
// Shared types and derived-constant helpers for the LUT neuron sweeper.
// Configuration legality is checked at elaboration through cfg_ok().
package lut_neuron_sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } sweep_state_t;

  function automatic int calc_k(input int word_w, input int out_bits);
    return word_w / out_bits;
  endfunction

  function automatic int calc_nwords(input int in_bits, input int word_w, input int out_bits);
    return int'(32'd1 << in_bits) / calc_k(word_w, out_bits);
  endfunction

  // Words must hold whole entries and the table must fill whole words.
  function automatic bit cfg_ok(input int in_bits, input int word_w, input int out_bits);
    return (out_bits > 0) && (word_w >= out_bits) && ((word_w % out_bits) == 0) &&
           (((int'(32'd1 << in_bits) * out_bits) % word_w) == 0);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lut_neuron_sweeper_if.sv
// Valid/ready stream carrying packed truth-table words out of the sweeper.
interface lut_neuron_sweeper_if #(
  parameter int WORD_W = 32
);
  logic              m_valid;
  logic              m_ready;
  logic [WORD_W-1:0] m_data;
  logic              m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/lut_neuron_sweeper_packer.sv
// Packs neuron codes into words and holds the single-entry output register.
// A capture that would complete a word is refused until the output slot frees up.
module lut_sweep_packer
  import lut_neuron_sweeper_pkg::*;
#(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 2,
  parameter int WORD_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cap_req,
  input  logic [IN_BITS-1:0]  lut_addr,
  input  logic [OUT_BITS-1:0] lut_data,
  output logic                advance,
  output logic                last_hs,
  lut_neuron_sweeper_if.master m
);
  localparam int K      = calc_k(WORD_W, OUT_BITS);
  localparam int NWORDS = calc_nwords(IN_BITS, WORD_W, OUT_BITS);
  localparam int KB     = idx_w(K);
  localparam int WB     = idx_w(NWORDS);
  localparam logic [KB-1:0]      ENTRY_LAST = KB'(K - 1);
  localparam logic [WB-1:0]      WORD_LAST  = WB'(NWORDS - 1);
  localparam logic [IN_BITS-1:0] ENTRY_MASK = IN_BITS'(K - 1);

  logic [WORD_W-1:0] pack_r;
  logic [WORD_W-1:0] pack_next_s;
  logic [WB-1:0]     word_idx_r;
  logic [KB-1:0]     entry_s;
  logic              word_end_s;
  logic              xfer_ok_s;
  logic              xfer_s;

  // Slot insertion, stall decision and final-handshake detect.
  always_comb begin
    entry_s     = KB'(lut_addr & ENTRY_MASK);
    pack_next_s = pack_r;
    pack_next_s[entry_s*OUT_BITS +: OUT_BITS] = lut_data;
    word_end_s  = (entry_s == ENTRY_LAST);
    xfer_ok_s   = !m.m_valid || m.m_ready;
    advance     = cap_req && (!word_end_s || xfer_ok_s);
    xfer_s      = advance && word_end_s;
    last_hs     = m.m_valid && m.m_ready && m.m_last;
  end

  // Pack register, word index and output register update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pack_r     <= {WORD_W{1'b0}};
      word_idx_r <= {WB{1'b0}};
      m.m_valid  <= 1'b0;
      m.m_last   <= 1'b0;
      m.m_data   <= {WORD_W{1'b0}};
    end else if (xfer_s) begin
      pack_r     <= {WORD_W{1'b0}};
      word_idx_r <= word_idx_r + WB'(1'b1);
      m.m_valid  <= 1'b1;
      m.m_last   <= (word_idx_r == WORD_LAST);
      m.m_data   <= pack_next_s;
    end else begin
      if (advance) begin
        pack_r <= pack_next_s;
      end
      // m_data is left as-is after the handshake; only the qualifiers drop.
      if (m.m_valid && m.m_ready) begin
        m.m_valid <= 1'b0;
        m.m_last  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/lut_neuron_sweeper.sv
// Sweeps every address of one combinational LUT neuron and streams the packed
// truth table out; this level owns the control FSM and the address counter.
module lut_neuron_sweeper
  import lut_neuron_sweeper_pkg::*;
#(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 2,
  parameter int WORD_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [IN_BITS-1:0]  lut_addr,
  input  logic [OUT_BITS-1:0] lut_data,
  lut_neuron_sweeper_if.master m
);
  localparam logic [IN_BITS-1:0] ADDR_LAST = {IN_BITS{1'b1}};

  if (!cfg_ok(IN_BITS, WORD_W, OUT_BITS)) begin : g_cfg_check
    $error("lut_neuron_sweeper: WORD_W/OUT_BITS/IN_BITS do not tile the truth table");
  end

  sweep_state_t state_r;
  logic         cap_req_s;
  logic         advance_s;
  logic         last_hs_s;

  assign cap_req_s = (state_r == ST_SWEEP);

  lut_sweep_packer #(
    .IN_BITS  (IN_BITS),
    .OUT_BITS (OUT_BITS),
    .WORD_W   (WORD_W)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .cap_req  (cap_req_s),
    .lut_addr (lut_addr),
    .lut_data (lut_data),
    .advance  (advance_s),
    .last_hs  (last_hs_s),
    .m        (m)
  );

  // Sweep control FSM with registered busy/done and the address counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      lut_addr <= {IN_BITS{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r  <= ST_SWEEP;
            busy     <= 1'b1;
            lut_addr <= {IN_BITS{1'b0}};
          end
        end
        ST_SWEEP: begin
          // The last capture only happens once its word has been moved out.
          if (advance_s) begin
            lut_addr <= lut_addr + IN_BITS'(1'b1);
            if (lut_addr == ADDR_LAST) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (last_hs_s) begin
            state_r <= ST_FIN;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        ST_FIN: begin
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/lut_neuron_sweeper.md
Name: lut_neuron_sweeper

Overview:
- Drives exhaustive input patterns into one generated LUT neuron over the neuron's address port.
- Captures every output code and streams the packed truth table out on a valid/ready interface.
- Sits in the verification/readback path. Dumped tables are compared against the training-side truth tables, and neurons are characterised on hardware without a re-synthesis.
- The neuron itself stays combinational; this block is the initiator that reads it.

Parameters:
- IN_BITS, 8, width of the neuron input bus; the sweep covers 2^IN_BITS addresses.
- OUT_BITS, 2, width of the neuron output code.
- WORD_W, 32, packed output word width. Must be a multiple of OUT_BITS; (2^IN_BITS*OUT_BITS) must be a multiple of WORD_W.
- Derived, K = WORD_W/OUT_BITS (entries per word, 16 at defaults).
- Derived, NWORDS = 2^IN_BITS/K (16 at defaults).

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; ignored unless idle.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last word is accepted.
- lut_addr  out  IN_BITS  registered address driven into the neuron input.
- lut_data  in  OUT_BITS  neuron output, combinational from lut_addr.
- m_valid  out  1  packed word available.
- m_ready  in  1  downstream accept.
- m_data  out  WORD_W  packed word.
- m_last  out  1  high with the final word (index NWORDS-1).

Behaviour:
- Reset (async, any state) clears:
  - state=IDLE;
  - busy, done, m_valid, m_last = 0;
  - m_data = 0, lut_addr = 0;
  - entry counter, pack register and word counter = 0.
- Sweep in progress at reset: aborted, no partial word emitted.
- States: IDLE, SWEEP, DRAIN, FIN.
- IDLE:
  - start=1 -> SWEEP, lut_addr=0, busy=1 next cycle.
  - start while not IDLE is ignored.
- SWEEP: each non-stalled cycle:
  - capture lut_data into pack bits [(a mod K)*OUT_BITS +: OUT_BITS], where a = current lut_addr (entry 0 at LSBs);
  - then increment lut_addr.
  - lut_data is sampled the same cycle lut_addr is stable (combinational neuron, no wait state).
- Word completion: when entry K-1 of a word is captured, the full word (including the just-captured entry) moves into the output register.
  - m_valid=1 next cycle.
  - m_last=1 if the word index is NWORDS-1.
  - The pack register is cleared.
- Output register: single entry.
  - A word transfer is allowed when m_valid=0, or when m_valid && m_ready in the same cycle (zero-bubble refill).
- Stall:
  - Applies when the capture would complete a word and the transfer is not allowed.
  - lut_addr holds, no capture, pack register holds.
  - Retried every cycle until allowed.
- m_data, m_last stable while m_valid && !m_ready. m_valid drops only on handshake.
- After the final capture (a = 2^IN_BITS-1): lut_addr wraps to 0, and the state goes to DRAIN once the final word is transferred.
- DRAIN: wait for handshake with m_last=1 -> FIN.
- FIN: done=1 for one cycle, busy=0 in that cycle; -> IDLE.
- Latency at defaults, m_ready=1, start at cycle 0:
  - captures occur cycles 1..256;
  - first m_valid at cycle 17;
  - words every 16 cycles;
  - final handshake at cycle 257;
  - done at cycle 258.
- No arithmetic beyond counters. Counters are exact width (IN_BITS; log2(NWORDS)) and wrap naturally.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/SWEEP/DRAIN/FIN);
  - derived-constant functions K and NWORDS;
  - elaboration-time check of the divisibility rules.
- One natural sub-module: lut_sweep_packer. It contains the pack register, word index and output register with the valid/ready stall logic.
- The top holds the FSM and the address counter.

Test Plan:
- Model lut_data = lut_addr[1:0], m_ready=1, start pulse:
  - 16 words, each 0xE4E4E4E4;
  - m_last only on the 16th;
  - done at cycle 258.
- Model lut_data = 2'b11 if lut_addr==8'hFC else 2'b00:
  - word 15 = 0x03000000 (entry 12 of word 15 = 3);
  - all other words 0.
- m_ready=0 for 40 cycles after the first m_valid:
  - m_data held constant;
  - lut_addr freezes at 31;
  - after release, the remaining words are bit-exact and none are lost or duplicated.
- m_ready random 50%, model lut_data = lut_addr[7:6]:
  - scoreboard matches all 16 words;
  - m_last exactly once;
  - done one cycle after the final handshake.
- start pulsed again at cycle 100 mid-sweep: ignored, output identical to the undisturbed run.
- rst asserted asynchronously at cycle 70:
  - all outputs 0 immediately;
  - a following start produces a full, correct sweep beginning at word 0.
